// File: rtl/bin2bcd_if.sv
// bin2bcd_if: valid/ready operand and result channels of the binary-to-BCD converter
interface bin2bcd_if #(parameter int WIDTH = 8, parameter int DIGITS = 3);
  localparam int NDW = $clog2(DIGITS + 1);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [4*DIGITS-1:0] out_bcd;
  logic [NDW-1:0] out_ndigits;
  logic busy;
  modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_bcd, out_ndigits, busy);
  modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_bcd, out_ndigits, busy);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble binary-to-BCD converter, one input bit per clock
module bin2bcd_seq #(
  parameter int WIDTH = 8,
  parameter int DIGITS = 3
) (
  input logic clk,
  input logic rst_n,
  bin2bcd_if.slave bus
);
  localparam int CNTW = $clog2(WIDTH + 1);
  localparam int NDW = $clog2(DIGITS + 1);
  localparam int SW = 4 * DIGITS;
  function automatic longint unsigned pow10(input int n);
    longint unsigned r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("bin2bcd_seq: WIDTH must be 2..32");
  end
  if (pow10(DIGITS) <= (64'd1 << WIDTH) - 64'd1) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small to hold 2**WIDTH-1");
  end
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [SW-1:0] scr, scr_n, adj, bcd;
  logic [CNTW-1:0] cnt;
  logic [NDW-1:0] nd, nd_n;
  logic unused_top;
  // top scratch bit never survives the shift when DIGITS is large enough
  assign unused_top = adj[SW-1];
  always_comb begin
    for (int i = 0; i < DIGITS; i++) adj[4*i+:4] = scr[4*i+:4] >= 4'd5 ? scr[4*i+:4] + 4'd3 : scr[4*i+:4];
    {scr_n, sh_n} = {adj[SW-2:0], sh, 1'b0};
    nd_n = NDW'(1);
    for (int i = 0; i < DIGITS; i++) if (scr_n[4*i+:4] != 4'd0) nd_n = NDW'(i + 1);
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = bus.in_valid ? CONV : IDLE;
      CONV: state_n = cnt == CNTW'(1) ? DONE : CONV;
      DONE: state_n = bus.out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sh <= '0;
      scr <= '0;
      cnt <= '0;
      bcd <= '0;
      nd <= NDW'(1);
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        sh <= bus.in_data;
        scr <= '0;
        cnt <= CNTW'(WIDTH);
      end else if (state == CONV) begin
        sh <= sh_n;
        scr <= scr_n;
        cnt <= cnt - CNTW'(1);
        if (cnt == CNTW'(1)) begin
          bcd <= scr_n;
          nd <= nd_n;
        end
      end
    end
  end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.out_bcd = bcd;
  assign bus.out_ndigits = nd;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed and random checks of bin2bcd_seq at 8/3, 4/2 and 16/5 widths
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  bin2bcd_if #(.WIDTH(8), .DIGITS(3)) b8();
  bin2bcd_if #(.WIDTH(4), .DIGITS(2)) b4();
  bin2bcd_if #(.WIDTH(16), .DIGITS(5)) b16();
  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut8(.clk(clk), .rst_n(rst_n), .bus(b8));
  bin2bcd_seq #(.WIDTH(4), .DIGITS(2)) dut4(.clk(clk), .rst_n(rst_n), .bus(b4));
  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut16(.clk(clk), .rst_n(rst_n), .bus(b16));
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    for (int i = 0; i < 5; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  function automatic int ref_nd(input int unsigned v);
    int n = 1;
    while (v >= 10) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction
  task automatic run8(input logic [7:0] v, input bit drain, output logic [11:0] bcd, output logic [1:0] nd, output int lat);
    @(negedge clk);
    b8.in_valid = 1'b1;
    b8.in_data = v;
    @(posedge clk);
    #1 b8.in_valid = 1'b0;
    lat = 0;
    while (!b8.out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (b8.out_bcd[4*d+:4] > 4'd9) begin failures++; $display("FAIL digit8 d=%0d got=%h want<=9", d, b8.out_bcd[4*d+:4]); end
      end
    end
    bcd = b8.out_bcd;
    nd = b8.out_ndigits;
    if (drain) begin
      b8.out_ready = 1'b1;
      @(posedge clk);
      #1 b8.out_ready = 1'b0;
    end
  endtask
  task automatic run4(input logic [3:0] v, output logic [7:0] bcd, output logic [1:0] nd, output int lat);
    @(negedge clk);
    b4.in_valid = 1'b1;
    b4.in_data = v;
    @(posedge clk);
    #1 b4.in_valid = 1'b0;
    lat = 0;
    while (!b4.out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    bcd = b4.out_bcd;
    nd = b4.out_ndigits;
    b4.out_ready = 1'b1;
    @(posedge clk);
    #1 b4.out_ready = 1'b0;
  endtask
  task automatic run16(input logic [15:0] v, output logic [19:0] bcd, output logic [2:0] nd, output int lat);
    @(negedge clk);
    b16.in_valid = 1'b1;
    b16.in_data = v;
    @(posedge clk);
    #1 b16.in_valid = 1'b0;
    lat = 0;
    while (!b16.out_valid && lat < 60) begin
      @(posedge clk);
      #1 lat++;
      for (int d = 0; d < 5; d++) begin
        checks++;
        if (b16.out_bcd[4*d+:4] > 4'd9) begin failures++; $display("FAIL digit16 d=%0d got=%h want<=9", d, b16.out_bcd[4*d+:4]); end
      end
    end
    bcd = b16.out_bcd;
    nd = b16.out_ndigits;
    b16.out_ready = 1'b1;
    @(posedge clk);
    #1 b16.out_ready = 1'b0;
  endtask
  task automatic test_basic();
    logic [7:0] vin[5] = '{8'd0, 8'd255, 8'd9, 8'd10, 8'd100};
    logic [11:0] vexp[5] = '{12'h000, 12'h255, 12'h009, 12'h010, 12'h100};
    logic [1:0] ndexp[5] = '{2'd1, 2'd3, 2'd1, 2'd2, 2'd3};
    logic [11:0] bcd;
    logic [1:0] nd;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run8(vin[i], 1'b1, bcd, nd, lat);
      checks++;
      if (bcd !== vexp[i]) begin failures++; $display("FAIL basic_bcd in=%0d got=%h want=%h", vin[i], bcd, vexp[i]); end
      checks++;
      if (nd !== ndexp[i]) begin failures++; $display("FAIL basic_nd in=%0d got=%0d want=%0d", vin[i], nd, ndexp[i]); end
      checks++;
      if (lat != 8) begin failures++; $display("FAIL basic_latency in=%0d got=%0d want=8", vin[i], lat); end
    end
    checks++;
    if (b8.out_bcd !== 12'h100 || b8.out_valid !== 1'b0 || b8.in_ready !== 1'b1)
      begin failures++; $display("FAIL retain got bcd=%h valid=%b ready=%b want bcd=100 valid=0 ready=1", b8.out_bcd, b8.out_valid, b8.in_ready); end
  endtask
  task automatic test_reset();
    @(negedge clk);
    b8.in_valid = 1'b1;
    b8.in_data = 8'd77;
    @(posedge clk);
    #1 b8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({b8.in_ready, b8.out_valid, b8.out_bcd, b8.out_ndigits, b8.busy} !== {1'b1, 1'b0, 12'h000, 2'd1, 1'b0})
      begin failures++; $display("FAIL reset_values got rdy=%b vld=%b bcd=%h nd=%0d busy=%b want 1 0 000 1 0", b8.in_ready, b8.out_valid, b8.out_bcd, b8.out_ndigits, b8.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (b8.in_ready !== 1'b1 || b8.busy !== 1'b0) begin failures++; $display("FAIL reset_release got rdy=%b busy=%b want 1 0", b8.in_ready, b8.busy); end
  endtask
  task automatic test_legacy4();
    logic [7:0] bcd, exp_bcd;
    logic [1:0] nd, exp_nd;
    int lat;
    for (int v = 0; v < 16; v++) begin
      exp_bcd = v < 10 ? 8'(v) : 8'(16 + v - 10);
      exp_nd = v < 10 ? 2'd1 : 2'd2;
      run4(4'(v), bcd, nd, lat);
      checks++;
      if (bcd !== exp_bcd || nd !== exp_nd || lat != 4)
        begin failures++; $display("FAIL legacy4 in=%0d got bcd=%h nd=%0d lat=%0d want bcd=%h nd=%0d lat=4", v, bcd, nd, lat, exp_bcd, exp_nd); end
    end
  endtask
  task automatic test_backpressure();
    logic [11:0] bcd;
    logic [1:0] nd;
    int lat;
    run8(8'd123, 1'b0, bcd, nd, lat);
    checks++;
    if (bcd !== 12'h123 || nd !== 2'd3) begin failures++; $display("FAIL bp_result got bcd=%h nd=%0d want 123 3", bcd, nd); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      b8.in_valid = i[0];
      b8.in_data = 8'd55;
      @(posedge clk);
      #1;
      checks++;
      if (b8.out_valid !== 1'b1 || b8.out_bcd !== 12'h123 || b8.in_ready !== 1'b0 || b8.out_ndigits !== 2'd3)
        begin failures++; $display("FAIL bp_hold cyc=%0d got vld=%b bcd=%h rdy=%b want 1 123 0", i, b8.out_valid, b8.out_bcd, b8.in_ready); end
    end
    @(negedge clk);
    b8.in_valid = 1'b1;
    b8.in_data = 8'd200;
    b8.out_ready = 1'b1;
    @(posedge clk);
    #1 b8.out_ready = 1'b0;
    checks++;
    if (b8.out_valid !== 1'b0 || b8.in_ready !== 1'b1) begin failures++; $display("FAIL bp_drain got vld=%b rdy=%b want 0 1", b8.out_valid, b8.in_ready); end
    @(posedge clk);
    #1 b8.in_valid = 1'b0;
    checks++;
    if (b8.busy !== 1'b1 || b8.in_ready !== 1'b0) begin failures++; $display("FAIL bp_accept got busy=%b rdy=%b want 1 0", b8.busy, b8.in_ready); end
    lat = 0;
    while (!b8.out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    checks++;
    if (b8.out_bcd !== 12'h200 || lat != 8) begin failures++; $display("FAIL bp_next got bcd=%h lat=%0d want 200 8", b8.out_bcd, lat); end
    b8.out_ready = 1'b1;
    @(posedge clk);
    #1 b8.out_ready = 1'b0;
  endtask
  task automatic test_abort();
    logic [11:0] bcd;
    logic [1:0] nd;
    int lat;
    bit seen = 1'b0;
    @(negedge clk);
    b8.in_valid = 1'b1;
    b8.in_data = 8'd200;
    @(posedge clk);
    #1 b8.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (b8.out_valid !== 1'b0 || b8.busy !== 1'b0 || b8.out_bcd !== 12'h000)
      begin failures++; $display("FAIL abort_reset got vld=%b busy=%b bcd=%h want 0 0 000", b8.out_valid, b8.busy, b8.out_bcd); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 if (b8.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL abort_no_valid got out_valid pulse want none"); end
    run8(8'd37, 1'b1, bcd, nd, lat);
    checks++;
    if (bcd !== 12'h037 || nd !== 2'd2 || lat != 8) begin failures++; $display("FAIL abort_next got bcd=%h nd=%0d lat=%0d want 037 2 8", bcd, nd, lat); end
  endtask
  task automatic test_random16();
    logic [19:0] bcd;
    logic [2:0] nd;
    int lat;
    logic [15:0] v;
    for (int i = 0; i < 34; i++) begin
      v = i == 0 ? 16'd0 : i == 1 ? 16'd65535 : i == 2 ? 16'd9999 : i == 3 ? 16'd10000 : 16'($urandom_range(0, 65535));
      run16(v, bcd, nd, lat);
      checks++;
      if (bcd !== ref_bcd(v) || nd !== 3'(ref_nd(v)) || lat != 16)
        begin failures++; $display("FAIL rand16 in=%0d got bcd=%h nd=%0d lat=%0d want bcd=%h nd=%0d lat=16", v, bcd, nd, lat, ref_bcd(v), ref_nd(v)); end
    end
  endtask
  initial begin
    {b8.in_valid, b8.out_ready, b4.in_valid, b4.out_ready, b16.in_valid, b16.out_ready} = '0;
    b8.in_data = '0;
    b4.in_data = '0;
    b16.in_data = '0;
    #12 rst_n = 1'b1;
    test_basic();
    test_reset();
    test_legacy4();
    test_backpressure();
    test_abort();
    test_random16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
